memory_stage: RTL and testbench
===============================

# memory_stage

Pipeline MEM stage sitting directly downstream of the execute stage: consumes the ALU result (effective address or arithmetic result) and the forwarded second operand (store data), performs byte/halfword/word loads and stores over a req/ack data bus, and registers the MEM/WB result. Stalls upstream while a bus transaction is outstanding and flags misaligned accesses as address-error exceptions.

## Interface
- TIMEOUT, 16, bus watchdog limit in cycles (used only with MEM_TIMEOUT_EN)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous reset, active-high
- i_valid  in  1  instruction present from execute
- i_memRead  in  1  load
- i_memWrite  in  1  store
- i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- i_signed  in  1  load sign-extends (1) or zero-extends (0)
- i_regWrite  in  1  instruction writes register file
- i_rd  in  5  destination register
- i_ALUres  in  32  address for loads/stores, result otherwise
- i_op2  in  32  store data
- o_stall  out  1  upstream must hold all i_* stable
- o_bus_req  out  1  bus request
- o_bus_we  out  1  1 = write
- o_bus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_bus_be  out  4  byte enables, little-endian
- o_bus_wdata  out  32  lane-replicated store data
- i_bus_ack  in  1  transaction complete; i_bus_rdata valid
- i_bus_rdata  in  32  read data
- o_valid  out  1  instruction retires to writeback this cycle
- o_regWrite  out  1  writeback enable
- o_rd  out  5  writeback register
- o_wbData  out  32  writeback data
- o_adel  out  1  load address error (pulse with o_valid)
- o_ades  out  1  store address error (pulse with o_valid)
- o_buserr  out  1  bus timeout (pulse with o_valid)

## Operation
- Memory op = i_valid & (i_memRead | i_memWrite); both set → treated as load.
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0. No bus access; retire next edge with o_adel/o_ades=1, o_regWrite=0, o_wbData=i_ALUres.
- FSM IDLE/BUSY.
  - IDLE, aligned memory op: latch addr, size, signed, rd, regWrite, we; drive req/we/addr/be/wdata registered; → BUSY.
  - BUSY: hold all bus outputs stable; on i_bus_ack → retire, → IDLE.
- Non-memory valid instruction in IDLE: retire next edge, o_wbData=i_ALUres, rd/regWrite passed through.
- i_valid=0 or stalled: o_valid=0, o_regWrite=0 (bubble); o_rd/o_wbData hold.
- Byte enables: byte 4'b0001<<a[1:0]; half 4'b0011<<a[1:0]; word 4'hF. wdata: byte {4{op2[7:0]}}, half {2{op2[15:0]}}, word op2.
- Load data: rdata>>(8*a[1:0]), low 8/16 bits sign- or zero-extended; word unchanged. Stores retire with o_regWrite=0.

## Timing
- o_stall combinational: (IDLE & aligned memory op) | (BUSY & ~i_bus_ack).
- Non-memory / misaligned latency 1 cycle; memory op ≥2 cycles (request edge, ack edge). Zero-wait slave acking first BUSY cycle → 2 cycles.
- i_bus_ack sampled only in BUSY; ack in IDLE ignored.
- o_bus_req falls on the edge after ack; a new request may be issued the following edge at the earliest (no back-to-back without IDLE cycle).
- Reset (async, any state incl. mid-transaction): state IDLE, o_bus_req=0, all outputs 0 immediately; aborted transaction never retires; an ack arriving after reset is ignored.

## Configuration
- MEM_TIMEOUT_EN defined: counter clears on entering BUSY, increments each BUSY cycle without ack; at count TIMEOUT-1 with no ack, drop req, retire with o_buserr=1, o_regWrite=0, → IDLE. Ack on the same cycle as expiry wins (normal retire).
- Undefined: BUSY waits indefinitely; o_buserr tied 0; no counter.

## Test plan
- ADD result 0x0000_1234, rd=5, regWrite=1 → next edge o_valid=1, o_wbData=0x1234, o_rd=5, o_stall never high.
- LB signed, addr 0x103, ack after 3 wait cycles with rdata 0x80AA_BBCC → be=4'b1000, o_stall high 4 cycles, o_wbData=0xFFFF_FF80.
- SH addr 0x202, op2 0xDEAD_BEEF, immediate ack → o_bus_we=1, addr 0x200, be=4'b1100, wdata 0xBEEF_BEEF, o_regWrite=0 on retire.
- LW addr 0x301 → no o_bus_req, o_adel=1, o_regWrite=0, o_wbData=0x301; SW addr 0x302 → o_ades=1.
- Reset asserted in BUSY, then stray ack → o_bus_req low immediately, no retire, FSM IDLE.
- MEM_TIMEOUT_EN, TIMEOUT=16, never ack → o_buserr=1 with o_valid after 16 BUSY cycles, o_stall released same cycle.

Source files
------------

// File: rtl/memory_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack bus, MEM/WB result register.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN (limit set by TIMEOUT).
module memory_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_memRead,
  input  logic        i_memWrite,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic        i_regWrite,
  input  logic [4:0]  i_rd,
  input  logic [31:0] i_ALUres,
  input  logic [31:0] i_op2,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_valid,
  output logic        o_regWrite,
  output logic [4:0]  o_rd,
  output logic [31:0] o_wbData,
  output logic        o_adel,
  output logic        o_ades,
  output logic        o_buserr
);

  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;

  logic        req_q, req_d, we_q, we_d, sgn_q, sgn_d, prw_q, prw_d;
  logic [1:0]  size_q, size_d, lane_q, lane_d;
  logic [4:0]  prd_q, prd_d, rd_q, rd_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wb_q, wb_d;
  logic        vld_q, vld_d, rw_q, rw_d, adel_q, adel_d, ades_q, ades_d, berr_q, berr_d;
  logic        mem_op, misalign, aligned_mem, expire, stall;

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   be_f = 4'b0001 << a;
      2'b01:   be_f = 4'b0011 << a;
      default: be_f = 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   wdata_f = {4{d[7:0]}};
      2'b01:   wdata_f = {2{d[15:0]}};
      default: wdata_f = d;
    endcase
  endfunction

  function automatic logic [31:0] load_f(input logic [1:0] sz, input logic sg,
                                         input logic [1:0] a, input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (sz)
      2'b00:   load_f = {{24{sg & sh[7]}}, sh[7:0]};
      2'b01:   load_f = {{16{sg & sh[15]}}, sh[15:0]};
      default: load_f = rdata;
    endcase
  endfunction

  assign mem_op      = i_valid & (i_memRead | i_memWrite);
  assign misalign    = ((i_size == 2'b01) & i_ALUres[0]) | (i_size[1] & (|i_ALUres[1:0]));
  assign aligned_mem = mem_op & ~misalign;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign expire = (state_q == BUSY) & ~i_bus_ack & (cnt_q == LAST);

  // Counter sits at zero in IDLE, so it starts from zero on entering BUSY
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = '0;
    else if (!i_bus_ack)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aligned_mem) state_d = BUSY;
      BUSY:    if (i_bus_ack | expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    req_d = req_q;   we_d = we_q;     addr_d = addr_q; be_d = be_q; wdata_d = wdata_q;
    size_d = size_q; sgn_d = sgn_q;   lane_d = lane_q; prd_d = prd_q; prw_d = prw_q;
    vld_d = 1'b0;    rw_d = 1'b0;     rd_d = rd_q;     wb_d = wb_q;
    adel_d = 1'b0;   ades_d = 1'b0;   berr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (aligned_mem) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = ~i_memRead;
          addr_d  = {i_ALUres[31:2], 2'b00};
          be_d    = be_f(i_size, i_ALUres[1:0]);
          wdata_d = wdata_f(i_size, i_op2);
          size_d  = i_size;
          sgn_d   = i_signed;
          lane_d  = i_ALUres[1:0];
          prd_d   = i_rd;
          prw_d   = i_regWrite;
        end else if (i_valid) begin
          vld_d = 1'b1;
          rd_d  = i_rd;
          wb_d  = i_ALUres;
          if (mem_op) begin
            adel_d = i_memRead;
            ades_d = ~i_memRead;
          end else begin
            rw_d = i_regWrite;
          end
        end
      end
      BUSY: begin
        stall = ~i_bus_ack & ~expire;
        if (i_bus_ack | expire) begin
          req_d  = 1'b0;
          vld_d  = 1'b1;
          rd_d   = prd_q;
          rw_d   = i_bus_ack & prw_q & ~we_q;
          berr_d = ~i_bus_ack;
          if (i_bus_ack & ~we_q) wb_d = load_f(size_q, sgn_q, lane_q, i_bus_rdata);
        end
      end
      default: ;
    endcase
  end

  // Bus request and MEM/WB registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      req_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; be_q <= '0; wdata_q <= '0;
      size_q <= '0; sgn_q <= 1'b0; lane_q <= '0; prd_q <= '0; prw_q <= 1'b0;
      vld_q <= 1'b0; rw_q <= 1'b0; rd_q <= '0; wb_q <= '0;
      adel_q <= 1'b0; ades_q <= 1'b0; berr_q <= 1'b0;
    end else begin
      req_q <= req_d; we_q <= we_d; addr_q <= addr_d; be_q <= be_d; wdata_q <= wdata_d;
      size_q <= size_d; sgn_q <= sgn_d; lane_q <= lane_d; prd_q <= prd_d; prw_q <= prw_d;
      vld_q <= vld_d; rw_q <= rw_d; rd_q <= rd_d; wb_q <= wb_d;
      adel_q <= adel_d; ades_q <= ades_d; berr_q <= berr_d;
    end
  end

  assign o_stall     = stall;
  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_be    = be_q;
  assign o_bus_wdata = wdata_q;
  assign o_valid     = vld_q;
  assign o_regWrite  = rw_q;
  assign o_rd        = rd_q;
  assign o_wbData    = wb_q;
  assign o_adel      = adel_q;
  assign o_ades      = ades_q;
  assign o_buserr    = berr_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table for single-cycle retires, bus-slave sequences
// and randomized loads/stores against a byte-level reference model.
module tb_memory_stage;

  logic        clk = 1'b0, rst = 1'b1;
  logic        valid = 0, mrd = 0, mwr = 0, sgn = 0, rw = 0, ack = 0;
  logic [1:0]  size = 0;
  logic [4:0]  rd = 0;
  logic [31:0] alu = 0, op2 = 0, rdata = 0;
  logic        stall, req, we, ov, orw, adel, ades, berr;
  logic [31:0] baddr, bwdata, wb;
  logic [3:0]  be;
  logic [4:0]  ord;

  int total = 0, bad = 0;

  memory_stage dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_memRead(mrd), .i_memWrite(mwr),
    .i_size(size), .i_signed(sgn), .i_regWrite(rw), .i_rd(rd), .i_ALUres(alu), .i_op2(op2),
    .o_stall(stall), .o_bus_req(req), .o_bus_we(we), .o_bus_addr(baddr), .o_bus_be(be),
    .o_bus_wdata(bwdata), .i_bus_ack(ack), .i_bus_rdata(rdata), .o_valid(ov),
    .o_regWrite(orw), .o_rd(ord), .o_wbData(wb), .o_adel(adel), .o_ades(ades), .o_buserr(berr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a size-n access touches bytes a..a+n-1 of the little-endian word
  task automatic run_mem(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic rwr,
                         input logic [4:0] r, input int waits, input logic [31:0] rdat);
    int n, lane, stalls;
    logic [3:0] ebe;
    logic [31:0] ewd;
    longint val;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(a % 4);
    valid = 1; mrd = ld; mwr = ~ld; size = sz; sgn = sg; alu = a; op2 = d; rw = rwr; rd = r;
    ack = 0;
    #1;
    if ((a % n) != 0) begin
      chk("mis_stall", 32'(stall), 0);
      step();
      valid = 0;
      chk("mis_valid", 32'(ov), 1);
      chk("mis_adel", 32'(adel), 32'(ld));
      chk("mis_ades", 32'(ades), 32'(!ld));
      chk("mis_regw", 32'(orw), 0);
      chk("mis_wb", wb, a);
      chk("mis_noreq", 32'(req), 0);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      ebe[k] = (k >= lane) && (k < lane + n);
      ewd[8*k +: 8] = 8'(d >> (8 * (k % n)));
    end
    val = 0;
    for (int k = 0; k < n; k++) val = val | (longint'((rdat >> (8 * (lane + k))) & 32'hFF) << (8 * k));
    if (sg && n < 4 && val >= (longint'(1) << (8 * n - 1))) val = val - (longint'(1) << (8 * n));
    chk("req_stall", 32'(stall), 1);
    chk("req_before_edge", 32'(req), 0);
    stalls = 1;
    step();
    chk("bus_req", 32'(req), 1);
    chk("bus_we", 32'(we), 32'(!ld));
    chk("bus_addr", baddr, a & ~32'd3);
    chk("bus_be", 32'(be), 32'(ebe));
    if (!ld) chk("bus_wdata", bwdata, ewd);
    for (int w = 0; w < waits; w++) begin
      if (stall) stalls++;
      step();
    end
    chk("req_held", 32'(req), 1);
    ack = 1; rdata = rdat;
    #1;
    chk("ack_stall", 32'(stall), 0);
    chk("stall_cycles", 32'(stalls), 32'(waits + 1));
    step();
    ack = 0; valid = 0; rdata = $urandom;
    chk("ret_valid", 32'(ov), 1);
    chk("ret_regw", 32'(orw), 32'(ld & rwr));
    chk("ret_rd", 32'(ord), 32'(r));
    if (ld) chk("ret_wb", wb, 32'(val));
    chk("ret_exc", 32'({adel, ades, berr}), 0);
    chk("ret_req_low", 32'(req), 0);
  endtask

  typedef struct {
    logic v, mr, mw; logic [1:0] sz; logic rw; logic [4:0] rd; logic [31:0] alu;
    logic e_v, e_rw, e_adel, e_ades, chk_rd; logic [4:0] e_rd; logic [31:0] e_wb;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 0, 2'd2, 1, 5'd5, 32'h0000_1234, 1, 1, 0, 0, 1, 5'd5, 32'h0000_1234};
    tbl[1] = '{1, 1, 0, 2'd2, 1, 5'd3, 32'h0000_0301, 1, 0, 1, 0, 0, 5'd0, 32'h0000_0301};
    tbl[2] = '{1, 0, 1, 2'd2, 1, 5'd4, 32'h0000_0302, 1, 0, 0, 1, 0, 5'd0, 32'h0000_0302};
    tbl[3] = '{1, 0, 0, 2'd0, 0, 5'd7, 32'hAAAA_5555, 1, 0, 0, 0, 1, 5'd7, 32'hAAAA_5555};
    tbl[4] = '{0, 1, 0, 2'd2, 1, 5'd9, 32'h0000_FFFF, 0, 0, 0, 0, 1, 5'd7, 32'hAAAA_5555};
    tbl[5] = '{1, 1, 0, 2'd1, 1, 5'd2, 32'h0000_0105, 1, 0, 1, 0, 0, 5'd0, 32'h0000_0105};
    tbl[6] = '{1, 0, 1, 2'd1, 0, 5'd2, 32'h0000_0201, 1, 0, 0, 1, 0, 5'd0, 32'h0000_0201};
    tbl[7] = '{1, 1, 1, 2'd2, 1, 5'd6, 32'h0000_0102, 1, 0, 1, 0, 0, 5'd0, 32'h0000_0102};
    tbl[8] = '{1, 1, 0, 2'd3, 1, 5'd8, 32'h0000_0106, 1, 0, 1, 0, 0, 5'd0, 32'h0000_0106};

    #2;
    chk("rst_valid", 32'(ov), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_wb", wb, 0);
    chk("rst_rd", 32'(ord), 0);
    chk("rst_flags", 32'({orw, adel, ades, berr, we}), 0);
    step(); step();
    rst = 0;
    step();

    for (int i = 0; i < 9; i++) begin
      valid = tbl[i].v; mrd = tbl[i].mr; mwr = tbl[i].mw; size = tbl[i].sz;
      rw = tbl[i].rw; rd = tbl[i].rd; alu = tbl[i].alu; sgn = 1;
      #1;
      chk($sformatf("tbl%0d_stall", i), 32'(stall), 0);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(ov), 32'(tbl[i].e_v));
      chk($sformatf("tbl%0d_regw", i), 32'(orw), 32'(tbl[i].e_rw));
      chk($sformatf("tbl%0d_adel", i), 32'(adel), 32'(tbl[i].e_adel));
      chk($sformatf("tbl%0d_ades", i), 32'(ades), 32'(tbl[i].e_ades));
      chk($sformatf("tbl%0d_wb", i), wb, tbl[i].e_wb);
      chk($sformatf("tbl%0d_req", i), 32'(req), 0);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rd", i), 32'(ord), 32'(tbl[i].e_rd));
    end
    valid = 0;
    step();

    // LB signed from the top byte lane, three wait states
    run_mem(1, 2'd0, 1, 32'h0000_0103, 32'h0, 1, 5'd10, 3, 32'h80AA_BBCC);
    chk("lb_value", wb, 32'hFFFF_FF80);
    // SH to upper half with a zero-wait slave, followed immediately by another load
    run_mem(0, 2'd1, 0, 32'h0000_0202, 32'hDEAD_BEEF, 1, 5'd11, 0, 32'h0);
    run_mem(1, 2'd1, 0, 32'h0000_0402, 32'h0, 1, 5'd12, 1, 32'h8001_1234);
    chk("lhu_value", wb, 32'h0000_8001);

    // Ack while idle must be ignored
    ack = 1;
    step();
    ack = 0;
    chk("idle_ack_valid", 32'(ov), 0);
    chk("idle_ack_req", 32'(req), 0);

    // Reset while a load is outstanding, then a stray ack
    valid = 1; mrd = 1; mwr = 0; size = 2'd2; alu = 32'h0000_0400; rd = 5'd13; rw = 1;
    step();
    chk("rst_busy_req", 32'(req), 1);
    valid = 0;
    rst = 1;
    #1;
    chk("rst_busy_req_low", 32'(req), 0);
    chk("rst_busy_valid", 32'(ov), 0);
    chk("rst_busy_stall", 32'(stall), 0);
    step();
    rst = 0; ack = 1; rdata = 32'h1234_5678;
    step();
    ack = 0;
    chk("stray_ack_valid", 32'(ov), 0);
    chk("stray_ack_req", 32'(req), 0);
    step();
    chk("stray_ack_valid2", 32'(ov), 0);
    run_mem(1, 2'd2, 0, 32'h0000_0500, 32'h0, 1, 5'd14, 2, 32'hCAFE_F00D);
    chk("post_rst_lw", wb, 32'hCAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      run_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              $urandom_range(0, 6), $urandom);
      step();
    end

`ifdef MEM_TIMEOUT_EN
    begin
      int busy_cycles;
      valid = 1; mrd = 1; mwr = 0; size = 2'd2; alu = 32'h0000_0600; rd = 5'd15; rw = 1;
      step();
      valid = 0;
      busy_cycles = 1;
      while (stall && busy_cycles < 40) begin
        busy_cycles++;
        step();
      end
      #1;
      chk("to_busy_cycles", 32'(busy_cycles), 16);
      step();
      chk("to_valid", 32'(ov), 1);
      chk("to_buserr", 32'(berr), 1);
      chk("to_regw", 32'(orw), 0);
      chk("to_req", 32'(req), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
